// File: rtl/aud_mix_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the N-channel stereo mixer.
package aud_mix_pkg;

    localparam logic [1:0] MIX_NONE = 2'd0;
    localparam logic [1:0] MIX_25   = 2'd1;
    localparam logic [1:0] MIX_50   = 2'd2;
    localparam logic [1:0] MIX_MONO = 2'd3;

    localparam int ATT_MUTE_BIT = 4;
    localparam int CLAMP_W      = 48;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_MIX,
        ST_ATT,
        ST_OUT
    } state_t;

    function automatic int calc_acc_w(input int channels, input int width);
        return width + $clog2(channels) + 2;
    endfunction

    function automatic logic signed [CLAMP_W-1:0] sat_max(input int width);
        return (CLAMP_W'(1) <<< (width - 1)) - CLAMP_W'(1);
    endfunction

    // Saturate v to the signed range of a width-bit sample (result sign-extended).
    function automatic logic signed [CLAMP_W-1:0] clamp_val(input logic signed [CLAMP_W-1:0] v,
                                                           input int width);
        logic signed [CLAMP_W-1:0] hi;
        logic signed [CLAMP_W-1:0] lo;
        hi = sat_max(width);
        lo = ~hi;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

    function automatic logic is_clip(input logic signed [CLAMP_W-1:0] v, input int width);
        return (v > sat_max(width)) || (v < ~sat_max(width));
    endfunction

endpackage

// File: rtl/aud_ch_scale.sv
// Converts one raw sample to accumulator format and applies its channel attenuation.
module aud_ch_scale
    import aud_mix_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = 20
) (
    input  logic [WIDTH-1:0]        sample,
    input  logic                    is_signed,
    input  logic [4:0]              att,
    output logic signed [ACC_W-1:0] term
);

    logic signed [ACC_W-1:0] ext;

    always_comb begin
        // Unsigned sources are halved so they fit the positive half of the signed range.
        if (is_signed)
            ext = {{(ACC_W-WIDTH){sample[WIDTH-1]}}, sample};
        else
            ext = {{(ACC_W-WIDTH+1){1'b0}}, sample[WIDTH-1:1]};

        if (att[ATT_MUTE_BIT])
            term = '0;
        else
            term = ext >>> att[3:0];
    end

endmodule

// File: rtl/aud_mix_nch.sv
// CHANNELS-input stereo mixer: serial accumulate, cross-mix, master attenuation, clamp.
// Optional input deglitch filter enabled with AUD_MIX_DEGLITCH_EN.
//
// state | meaning
// IDLE  | waiting for in_valid, snapshot inputs on acceptance
// ACC   | add one channel per cycle into acc_l/acc_r
// MIX   | apply stereo cross-mix mode to both accumulators
// ATT   | master attenuation, clamp, register outputs
// OUT   | out_valid pulse, then back to IDLE
module aud_mix_nch
    import aud_mix_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] ch_l,
    input  logic [CHANNELS*WIDTH-1:0] ch_r,
    input  logic [CHANNELS-1:0]       ch_signed,
    input  logic [CHANNELS*5-1:0]     ch_att,
    input  logic [4:0]                master_att,
    input  logic [1:0]                mix,
    input  logic                      clip_clr,
    output logic [WIDTH-1:0]          out_l,
    output logic [WIDTH-1:0]          out_r,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      clip_l,
    output logic                      clip_r,
    output logic                      overrun
);

    localparam int ACC_W = calc_acc_w(CHANNELS, WIDTH);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_t state, state_nx;

    logic [IDX_W-1:0]          idx;
    logic                      last_ch;
    logic signed [ACC_W-1:0]   acc_l, acc_r;
    logic signed [ACC_W-1:0]   term_l, term_r;
    logic signed [ACC_W-1:0]   mix_l, mix_r;
    logic signed [ACC_W-1:0]   att_l, att_r;
    logic [CHANNELS*WIDTH-1:0] snap_l, snap_r;
    logic [CHANNELS*WIDTH-1:0] cap_l, cap_r;
    logic [CHANNELS-1:0]       snap_sgn;
    logic [CHANNELS*5-1:0]     snap_att;
    logic [4:0]                snap_matt;
    logic [1:0]                snap_mix;
    logic [WIDTH-1:0]          cur_l, cur_r;
    logic                      cur_sgn;
    logic [4:0]                cur_att;
    logic                      set_clip_l, set_clip_r;

`ifdef AUD_MIX_DEGLITCH_EN
    // snap_l/snap_r double as the last accepted samples; raw_*_q hold the previous raw strobe.
    logic [CHANNELS*WIDTH-1:0] raw_l_q, raw_r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_l_q <= '0;
            raw_r_q <= '0;
        end else if (in_valid && state == ST_IDLE) begin
            raw_l_q <= ch_l;
            raw_r_q <= ch_r;
        end
    end

    always_comb begin
        cap_l = snap_l;
        cap_r = snap_r;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_l[k*WIDTH +: WIDTH] == raw_l_q[k*WIDTH +: WIDTH])
                cap_l[k*WIDTH +: WIDTH] = ch_l[k*WIDTH +: WIDTH];
            if (ch_r[k*WIDTH +: WIDTH] == raw_r_q[k*WIDTH +: WIDTH])
                cap_r[k*WIDTH +: WIDTH] = ch_r[k*WIDTH +: WIDTH];
        end
    end
`else
    assign cap_l = ch_l;
    assign cap_r = ch_r;
`endif

    assign last_ch = (idx == IDX_W'(CHANNELS - 1));
    assign busy    = (state != ST_IDLE);

    always_comb begin
        cur_l   = snap_l[int'(idx)*WIDTH +: WIDTH];
        cur_r   = snap_r[int'(idx)*WIDTH +: WIDTH];
        cur_sgn = snap_sgn[idx];
        cur_att = snap_att[int'(idx)*5 +: 5];
    end

    aud_ch_scale #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_scale_l (
        .sample    (cur_l),
        .is_signed (cur_sgn),
        .att       (cur_att),
        .term      (term_l)
    );

    aud_ch_scale #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_scale_r (
        .sample    (cur_r),
        .is_signed (cur_sgn),
        .att       (cur_att),
        .term      (term_r)
    );

    function automatic logic signed [ACC_W-1:0] mix_side(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] o,
                                                        input logic [1:0]              mode);
        case (mode)
            MIX_NONE: return a;
            MIX_25:   return a - (a >>> 3) + (o >>> 2);
            MIX_50:   return a - (a >>> 2) + (o >>> 1);
            default:  return (a >>> 1) + (o >>> 1);
        endcase
    endfunction

    always_comb begin
        mix_l = mix_side(acc_l, acc_r, snap_mix);
        mix_r = mix_side(acc_r, acc_l, snap_mix);
        if (snap_matt[ATT_MUTE_BIT]) begin
            att_l = '0;
            att_r = '0;
        end else begin
            att_l = acc_l >>> snap_matt[3:0];
            att_r = acc_r >>> snap_matt[3:0];
        end
        set_clip_l = (state == ST_ATT) && is_clip(CLAMP_W'(att_l), WIDTH);
        set_clip_r = (state == ST_ATT) && is_clip(CLAMP_W'(att_r), WIDTH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (in_valid) state_nx = ST_ACC;
            ST_ACC:  if (last_ch)  state_nx = ST_MIX;
            ST_MIX:  state_nx = ST_ATT;
            ST_ATT:  state_nx = ST_OUT;
            ST_OUT:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            snap_l    <= '0;
            snap_r    <= '0;
            snap_sgn  <= '0;
            snap_att  <= '0;
            snap_matt <= '0;
            snap_mix  <= MIX_NONE;
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            clip_l    <= 1'b0;
            clip_r    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        snap_l    <= cap_l;
                        snap_r    <= cap_r;
                        snap_sgn  <= ch_signed;
                        snap_att  <= ch_att;
                        snap_matt <= master_att;
                        snap_mix  <= mix;
                        idx       <= '0;
                        acc_l     <= '0;
                        acc_r     <= '0;
                    end
                end
                ST_ACC: begin
                    acc_l <= acc_l + term_l;
                    acc_r <= acc_r + term_r;
                    if (!last_ch)
                        idx <= idx + 1'b1;
                end
                ST_MIX: begin
                    acc_l <= mix_l;
                    acc_r <= mix_r;
                end
                ST_ATT: begin
                    out_l     <= WIDTH'(clamp_val(CLAMP_W'(att_l), WIDTH));
                    out_r     <= WIDTH'(clamp_val(CLAMP_W'(att_r), WIDTH));
                    out_valid <= 1'b1;
                end
                default: ;
            endcase

            // Sticky flags: a new event in the same cycle as clip_clr wins.
            clip_l  <= (clip_l && !clip_clr) || set_clip_l;
            clip_r  <= (clip_r && !clip_clr) || set_clip_r;
            overrun <= (overrun && !clip_clr) || (in_valid && state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_aud_mix_nch.sv
// Self-checking bench for aud_mix_nch (CHANNELS=4, WIDTH=16): vector table plus corner sequences.
module tb_aud_mix_nch;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam logic [19:0] M3 = {5'h10, 5'h10, 5'h10, 5'h00};

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [CH*W-1:0] ch_l = '0;
    logic [CH*W-1:0] ch_r = '0;
    logic [CH-1:0]   ch_signed = '0;
    logic [CH*5-1:0] ch_att = '0;
    logic [4:0]      master_att = '0;
    logic [1:0]      mix = '0;
    logic            clip_clr = 1'b0;
    logic [W-1:0]    out_l, out_r;
    logic            out_valid, busy, clip_l, clip_r, overrun;

    aud_mix_nch #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .ch_l       (ch_l),
        .ch_r       (ch_r),
        .ch_signed  (ch_signed),
        .ch_att     (ch_att),
        .master_att (master_att),
        .mix        (mix),
        .clip_clr   (clip_clr),
        .out_l      (out_l),
        .out_r      (out_r),
        .out_valid  (out_valid),
        .busy       (busy),
        .clip_l     (clip_l),
        .clip_r     (clip_r),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] l, r;
        logic [3:0]  sgn;
        logic [19:0] att;
        logic [4:0]  matt;
        logic [1:0]  mx;
        logic [15:0] el, er;
        logic        cl, cr;
    } vec_t;

    typedef struct {
        logic [15:0] el, er;
        logic        cl, cr;
        int          t0;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] l, input logic [63:0] r, input logic [3:0] s,
                                input logic [19:0] a, input logic [4:0] m, input logic [1:0] x,
                                input logic [15:0] el, input logic [15:0] er,
                                input logic cl, input logic cr);
        vec_t v;
        v.l = l; v.r = r; v.sgn = s; v.att = a; v.matt = m; v.mx = x;
        v.el = el; v.er = er; v.cl = cl; v.cr = cr;
        return v;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (out_valid) begin
            n_out++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got out_l=%h out_r=%h, required no output", out_l, out_r);
            end else begin
                e = sb.pop_front();
                chk("out_l",   {16'h0, out_l}, {16'h0, e.el});
                chk("out_r",   {16'h0, out_r}, {16'h0, e.er});
                chk("clip_l",  {31'h0, clip_l}, {31'h0, e.cl});
                chk("clip_r",  {31'h0, clip_r}, {31'h0, e.cr});
                chk("latency", cyc - e.t0, 7);
            end
        end
    end

    task automatic apply(input vec_t v);
        ch_l = v.l; ch_r = v.r; ch_signed = v.sgn; ch_att = v.att;
        master_att = v.matt; mix = v.mx;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.el = v.el; e.er = v.er; e.cl = v.cl; e.cr = v.cr; e.t0 = cyc;
        sb.push_back(e);
    endtask

    task automatic clear_flags();
        @(negedge clk) clip_clr = 1'b1;
        @(negedge clk) clip_clr = 1'b0;
        chk("clip_clr_l", {31'h0, clip_l}, 0);
        chk("clip_clr_r", {31'h0, clip_r}, 0);
        chk("clip_clr_ovr", {31'h0, overrun}, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("busy_done", {31'h0, busy}, 0);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int base;
        vecs[0]  = mk(64'h0000_0000_0000_1000, 64'h0, 4'hF, M3, 5'h00, 2'd0, 16'h1000, 16'h0000, 0, 0);
        vecs[1]  = mk({4{16'h7000}}, 64'h0, 4'hF, 20'h0, 5'h00, 2'd0, 16'h7FFF, 16'h0000, 1, 0);
        vecs[2]  = mk({4{16'h9000}}, 64'h0, 4'hF, 20'h0, 5'h00, 2'd0, 16'h8000, 16'h0000, 1, 0);
        vecs[3]  = mk(64'h0000_0000_0000_2000, 64'h0, 4'hF, M3, 5'h00, 2'd3, 16'h1000, 16'h1000, 0, 0);
        vecs[4]  = mk(64'h0000_0000_0000_2000, 64'h0, 4'hF, M3, 5'h00, 2'd1, 16'h1C00, 16'h0800, 0, 0);
        vecs[5]  = mk(64'h0000_0000_0000_FFFF, 64'h0, 4'hE, M3, 5'h00, 2'd0, 16'h7FFF, 16'h0000, 0, 0);
        vecs[6]  = mk(64'h0000_0000_0000_FFFF, 64'h0, 4'hE, {5'h10, 5'h10, 5'h10, 5'h03}, 5'h00, 2'd0,
                      16'h0FFF, 16'h0000, 0, 0);
        vecs[7]  = mk(64'h0000_0000_0000_FFFF, 64'h0, 4'hE, M3, 5'h10, 2'd0, 16'h0000, 16'h0000, 0, 0);
        vecs[8]  = mk(64'h0000_0000_0000_2000, 64'h0000_0000_0000_1000, 4'hF, M3, 5'h00, 2'd2,
                      16'h2000, 16'h1C00, 0, 0);
        vecs[9]  = mk(64'h0000_0000_1000_1000, 64'h0000_0000_0000_F000, 4'hF,
                      {5'h10, 5'h10, 5'h00, 5'h00}, 5'h02, 2'd0, 16'h0800, 16'hFC00, 0, 0);
        vecs[10] = mk(64'h0, {4{16'h7FFF}}, 4'hF, 20'h0, 5'h00, 2'd0, 16'h0000, 16'h7FFF, 0, 1);
        vecs[11] = mk(64'h0000_0000_0000_8000, 64'h0, 4'hF, {5'h10, 5'h10, 5'h10, 5'h04}, 5'h00, 2'd0,
                      16'hF800, 16'h0000, 0, 0);

        // Reset held with live inputs.
        apply(vecs[1]);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_l", {16'h0, out_l}, 0);
        chk("rst_out_r", {16'h0, out_r}, 0);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_clip", {30'h0, clip_l, clip_r}, 0);
        chk("rst_overrun", {31'h0, overrun}, 0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            clear_flags();
            apply(vecs[i]);
            in_valid = 1'b1;
            push_exp(vecs[i]);
            @(negedge clk) in_valid = 1'b0;
            wait_idle();
        end
        chk("table_outputs", n_out, 12);
        chk("table_queue_empty", sb.size(), 0);

        // Second strobe two cycles into a running mix.
        clear_flags();
        base = n_out;
        apply(vecs[0]);
        in_valid = 1'b1;
        push_exp(vecs[0]);
        @(negedge clk) in_valid = 1'b0;
        @(negedge clk);
        apply(vecs[3]);
        in_valid = 1'b1;
        @(negedge clk) in_valid = 1'b0;
        wait_idle();
        chk("overrun_flag", {31'h0, overrun}, 1);
        chk("overrun_single_out", n_out - base, 1);

        // Reset pulsed while accumulating channel 2.
        base = n_out;
        apply(vecs[3]);
        in_valid = 1'b1;
        @(negedge clk) in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_l", {16'h0, out_l}, 0);
        chk("midrst_busy", {31'h0, busy}, 0);
        chk("midrst_overrun", {31'h0, overrun}, 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_no_out", n_out - base, 0);
        chk("midrst_idle", {31'h0, busy}, 0);
        chk("final_queue_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/aud_mix_nch.md
Name: aud_mix_nch

Overview:
Parametrised successor to the two-channel stereo audio mixer. It mixes CHANNELS stereo sources into one clamped stereo output. Sources are summed by a time-multiplexed accumulator after each sample strobe. It applies per-channel and master attenuation and the four stereo cross-mix modes. It sits between the core audio sources (core, aux/CD, PSG taps) and the I2S audio_out serialiser, in the codec clock domain.

Parameters:
CHANNELS, 4, number of stereo sources (1..16)
WIDTH, 16, sample width in and out (8..24)
ACC_W, WIDTH+$clog2(CHANNELS)+2, accumulator width (derived, not overridden)

Ports:
clk  in  1  audio clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  sample strobe; snapshot all inputs
ch_l  in  CHANNELS*WIDTH  left samples, channel k at [k*WIDTH +: WIDTH]
ch_r  in  CHANNELS*WIDTH  right samples, same packing
ch_signed  in  CHANNELS  1 = two's complement, 0 = unsigned
ch_att  in  CHANNELS*5  per-channel attenuation: bit4 mute, [3:0] right-shift
master_att  in  5  bit4 mute, [3:0] arithmetic right-shift on the mixed result
mix  in  2  0 none, 1 25%, 2 50%, 3 mono
clip_clr  in  1  clears the sticky flags
out_l, out_r  out  WIDTH  signed mixed output
out_valid  out  1  one-cycle pulse; new out_l/out_r
busy  out  1  high from in_valid acceptance until out_valid
clip_l, clip_r  out  1  sticky: clamp occurred on that side
overrun  out  1  sticky: in_valid arrived while busy

Behaviour:
- Reset (async assert, sync deassert handled by the caller's reset bridge):
  - All outputs 0; FSM to IDLE; accumulators 0.
- FSM states: IDLE -> ACC -> MIX -> ATT -> OUT -> IDLE.
- IDLE: in_valid=1 snapshots ch_l, ch_r, ch_signed, ch_att, master_att and mix. Sets idx=0, acc_l=acc_r=0, busy=1, and moves to ACC.
- ACC: one channel per cycle. Per-channel conversion:
  - signed: sign-extend to ACC_W;
  - unsigned: {0, x[WIDTH-1:1]} (half scale, non-negative);
  - then >>> att[3:0], or 0 if att[4].
  - acc += term. After idx=CHANNELS-1, go to MIX.
- MIX, using a = own side, o = other side, full ACC_W signed:
  - mode 0: a;
  - mode 1: a - (a>>>3) + (o>>>2);
  - mode 2: a - (a>>>2) + (o>>>1);
  - mode 3: (a>>>1) + (o>>>1).
  - Both sides use pre-mix acc values; no cross-contamination.
- ATT: master mute forces 0; otherwise >>> master_att[3:0].
- OUT: clamp to signed WIDTH. Above max gives 2^(WIDTH-1)-1; below min gives -2^(WIDTH-1).
  - A clamp sets clip_l/clip_r.
  - out_l/out_r register; out_valid=1 for one cycle; busy=0; return to IDLE.
  - Outputs hold until the next OUT.
- Latency: in_valid at cycle T gives out_valid at T+CHANNELS+3.
- in_valid while busy: ignored, overrun<=1; the running mix is unaffected.
- in_valid in the same cycle as OUT: ignored (busy still 1).
- clip_clr and a new clip in the same cycle: the set wins. clip_clr also clears overrun.
- reset_n low mid-operation: immediate return to IDLE, outputs 0, no out_valid.

Optional Feature:
AUD_MIX_DEGLITCH_EN
- Defined: each channel and side keeps the last raw sample and the last accepted sample. At in_valid, a raw value equal to the previous raw value becomes accepted; otherwise the previous accepted value is used. This mirrors the legacy d2==d3 filter per strobe.
- Reset: accepted=raw history=0.
- Undefined: snapshot takes raw inputs directly; no extra registers.

Decomposition:
- Package aud_mix_pkg: mix-mode constants (MIX_NONE, MIX_25, MIX_50, MIX_MONO), FSM state enum, ATT_MUTE_BIT, clamp helper function, ACC_W computation function.
- One sub-module, aud_ch_scale: combinational conversion plus per-channel attenuation of one sample, instantiated once per side (shared across channels via idx mux).

Test Plan (CHANNELS=4, WIDTH=16):
- Reset / mid-operation reset:
  - reset_n low mid-reset -> all outputs 0, busy 0.
  - reset_n pulsed at ACC idx=2 -> no out_valid, IDLE, out_l=0.
- Single source: ch0 L=0x1000 signed, ch1..3 att=5'h10, mix=0 -> out_l=0x1000, out_r=0x0000, out_valid exactly 7 cycles after in_valid.
- Clamp:
  - all four L=0x7000 signed -> out_l=0x7FFF, clip_l=1;
  - all 0x9000 -> 0x8000;
  - clip_clr -> clip_l=0.
- Mono: ch0 L=0x2000, R=0, mix=3 -> out_l=out_r=0x1000; mix=1 -> out_l=0x1C00, out_r=0x0800.
- Unsigned and attenuation:
  - ch0 L=0xFFFF, ch_signed=0 -> out_l=0x7FFF;
  - ch_att=3 -> 0x0FFF;
  - master_att=5'h10 -> 0x0000.
- Overrun: second in_valid 2 cycles after the first -> single out_valid, result of the first snapshot, overrun=1.
